// File: rtl/cnn_frame_loader_if.sv
// Bundles the pixel stream, core-facing bus and result port of cnn_frame_loader.
// master = host/core side, slave = the loader itself.
interface cnn_frame_loader_if #(
  parameter int IMG_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32
);
  logic                       pix_valid;
  logic                       pix_ready;
  logic [DATA_W-1:0]          pix_data;
  logic [IMG_SIZE*DATA_W-1:0] core_img;
  logic                       core_enable;
  logic [OUT_W-1:0]           core_value;
  logic                       core_done;
  logic                       res_valid;
  logic                       res_ready;
  logic [OUT_W-1:0]           res_data;
  logic                       res_err;
  logic                       busy;

  modport master (
    output pix_valid, pix_data, core_value, core_done, res_ready,
    input  pix_ready, core_img, core_enable, res_valid, res_data, res_err, busy
  );

  modport slave (
    input  pix_valid, pix_data, core_value, core_done, res_ready,
    output pix_ready, core_img, core_enable, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/cnn_frame_loader.sv
// Buffers one frame of pixel words, runs it through a CNN core with a timeout
// watchdog, and hands the prediction back over a valid/ready result port.
module cnn_frame_loader #(
  parameter int IMG_SIZE = 64,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  cnn_frame_loader_if.slave bus
);

  localparam int PTR_W = $clog2(IMG_SIZE);
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [TMO_W-1:0]           r_tmo_cnt;
  logic [IMG_SIZE*DATA_W-1:0] r_buf;
  logic                       r_core_enable;
  logic                       r_res_valid;
  logic                       r_res_err;
  logic [OUT_W-1:0]           r_res_data;

  logic w_accept;
  logic w_last;
  logic w_done_hit;
  logic w_tmo_hit;
  logic w_res_take;

  // pix_ready is gated by rst so the source never sees a handshake during reset.
  assign w_accept   = (r_state == S_LOAD) && !rst && bus.pix_valid;
  assign w_last     = w_accept && (r_wr_ptr == PTR_W'(IMG_SIZE - 1));
  assign w_done_hit = (r_state == S_RUN) && bus.core_done;
  assign w_tmo_hit  = (r_state == S_RUN) && !bus.core_done &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign w_res_take = (r_state == S_OUT) && bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_last) w_next = S_RUN;
      S_RUN:   if (w_done_hit || w_tmo_hit) w_next = S_OUT;
      S_OUT:   if (w_res_take) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the frame buffer is reset because it drives core_img directly and
      // must read back as zero after reset; a plain RAM would not be reset.
      r_buf         <= '0;
      r_wr_ptr      <= '0;
      r_tmo_cnt     <= '0;
      r_core_enable <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_err     <= 1'b0;
      r_res_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every update here sees pre-edge values.
      if (w_accept) begin
        r_buf[r_wr_ptr*DATA_W +: DATA_W] <= bus.pix_data;
        r_wr_ptr <= w_last ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_last) begin
        r_core_enable <= 1'b1;
        r_tmo_cnt     <= '0;
      end
      if (r_state == S_RUN) begin
        // core_done takes priority over a simultaneous timeout.
        if (w_done_hit) begin
          r_res_data    <= bus.core_value;
          r_res_err     <= 1'b0;
          r_core_enable <= 1'b0;
          r_res_valid   <= 1'b1;
        end else if (w_tmo_hit) begin
          r_res_data    <= '0;
          r_res_err     <= 1'b1;
          r_core_enable <= 1'b0;
          r_res_valid   <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
      end
      if (w_res_take) r_res_valid <= 1'b0;
    end
  end

  assign bus.pix_ready   = (r_state == S_LOAD) && !rst;
  assign bus.core_img    = r_buf;
  assign bus.core_enable = r_core_enable;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_err     = r_res_err;
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_OUT);

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader: stimulus pushes expected frames and
// results, a monitor pops and compares whenever the DUT presents them.
module tb_cnn_frame_loader;
  localparam int IMG_SIZE = 64;
  localparam int DATA_W   = 32;
  localparam int OUT_W    = 32;
  localparam int TIMEOUT  = 1000;

  typedef logic [IMG_SIZE*DATA_W-1:0] img_t;
  typedef struct {
    logic [OUT_W-1:0] data;
    logic             err;
    int               en_len;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_frame_loader_if #(.IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  cnn_frame_loader #(
    .IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  img_t img_q[$];
  res_t res_q[$];

  // core model controls
  bit               core_auto  = 1'b0;
  int               done_after = 0;
  logic             force_done = 1'b0;
  logic [OUT_W-1:0] core_val   = '0;
  int               en_cnt     = 0;

  // monitor state
  logic prev_en  = 1'b0;
  int   mon_len  = 0;
  int   mon_bad  = 0;
  img_t mon_img  = '0;
  img_t mon_exp  = '0;
  res_t mon_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int pat, input int i);
    case (pat)
      0:       return DATA_W'(1);
      1:       return DATA_W'(i);
      2:       return DATA_W'(i * 3 + 7);
      3:       return 32'hA5A5_0000 | DATA_W'(i);
      default: return ~DATA_W'(i);
    endcase
  endfunction

  function automatic img_t frame_of(input int pat);
    img_t f;
    for (int i = 0; i < IMG_SIZE; i++) f[i*DATA_W +: DATA_W] = pix(pat, i);
    return f;
  endfunction

  // Core model: asserts done once core_enable has been high done_after cycles.
  initial begin
    bus.core_done  = 1'b0;
    bus.core_value = '0;
    forever begin
      @(negedge clk);
      if (bus.core_enable) en_cnt++;
      else                 en_cnt = 0;
      bus.core_value = core_val;
      bus.core_done  = bus.core_enable ? (core_auto && en_cnt == done_after) : force_done;
    end
  end

  // Monitor: checks the frame when core_enable rises, the result at handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.core_enable && !prev_en) begin
        mon_len = 0;
        if (img_q.size() == 0) begin
          check("img_unexpected", 1, 0);
        end else begin
          mon_exp = img_q.pop_front();
          mon_bad = IMG_SIZE - 1;
          for (int i = IMG_SIZE - 1; i >= 0; i--)
            if (bus.core_img[i*DATA_W +: DATA_W] !== mon_exp[i*DATA_W +: DATA_W]) mon_bad = i;
          check($sformatf("core_img[%0d]", mon_bad),
                bus.core_img[mon_bad*DATA_W +: DATA_W], mon_exp[mon_bad*DATA_W +: DATA_W]);
          mon_img = mon_exp;
        end
      end
      if (bus.core_enable) mon_len++;
      prev_en = bus.core_enable;
      if (bus.res_valid && bus.res_ready) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          mon_res = res_q.pop_front();
          check("res_data", bus.res_data, mon_res.data);
          check("res_err", bus.res_err, mon_res.err);
          check("enable_cycles", mon_len, mon_res.en_len);
          check("core_img_hold", bus.core_img == mon_img, 1);
        end
      end
    end
  end

  task automatic send_frame(input int pat, input bit gaps, input int n, input bit lat);
    int i     = 0;
    int waits = 0;
    bit gap   = 1'b0;
    while (i < n && waits < 200) begin
      @(negedge clk);
      if (gaps && gap) begin
        bus.pix_valid = 1'b0;
        gap = 1'b0;
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix(pat, i);
        if (bus.pix_ready) begin
          if (lat && i == IMG_SIZE - 1) check("enable_before_last", bus.core_enable, 0);
          i++;
          gap = 1'b1;
        end else begin
          waits++;
        end
      end
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    if (lat) check("enable_after_last", bus.core_enable, 1);
    check("words_accepted", i, n);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((res_q.size() != 0 || img_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", res_q.size() + img_q.size(), 0);
  endtask

  task automatic push(input int pat, input logic [OUT_W-1:0] d, input logic e, input int len);
    res_t r;
    r.data   = d;
    r.err    = e;
    r.en_len = len;
    img_q.push_back(frame_of(pat));
    res_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_core_enable", bus.core_enable, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_core_img_zero", bus.core_img == '0, 1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("pix_ready_after_rst", bus.pix_ready, 1);

    // Nominal: all-ones frame, done after 20 cycles with value 64
    core_auto = 1'b1; done_after = 20; core_val = 32'd64;
    push(0, 32'd64, 1'b0, 20);
    send_frame(0, 1'b0, IMG_SIZE, 1'b0);
    drain(300);

    // Stream gaps with data = index, enable latency checked around word 63
    done_after = 5; core_val = 32'h1234;
    push(1, 32'h1234, 1'b0, 5);
    send_frame(1, 1'b1, IMG_SIZE, 1'b1);
    drain(300);

    // Result backpressure
    done_after = 3; core_val = 32'd7;
    push(2, 32'd7, 1'b0, 3);
    bus.res_ready = 1'b0;
    send_frame(2, 1'b0, IMG_SIZE, 1'b0);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 32'd7);
      check("bp_pix_ready", bus.pix_ready, 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_pix_ready_after", bus.pix_ready, 1);
    check("bp_res_valid_after", bus.res_valid, 0);
    drain(50);

    // Timeout: core never completes
    core_auto = 1'b0; core_val = 32'hFFFF_FFFF;
    push(3, 32'd0, 1'b1, TIMEOUT);
    send_frame(3, 1'b0, IMG_SIZE, 1'b0);
    drain(1500);

    // core_done pulsed during LOAD is ignored
    core_auto = 1'b1; done_after = 4; core_val = 32'd99;
    push(4, 32'd99, 1'b0, 4);
    fork
      send_frame(4, 1'b0, IMG_SIZE, 1'b0);
      begin
        repeat (8) @(negedge clk);
        force_done = 1'b1;
        repeat (3) @(negedge clk);
        force_done = 1'b0;
      end
    join
    drain(300);

    // Reset during RUN, then a partial frame aborted by reset, then a clean frame
    done_after = 50; core_val = 32'd5;
    img_q.push_back(frame_of(2));
    send_frame(2, 1'b0, IMG_SIZE, 1'b0);
    repeat (10) @(negedge clk);
    check("run_enable_before_rst", bus.core_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_core_enable", bus.core_enable, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_pix_ready", bus.pix_ready, 0);
    #1 rst = 1'b0;
    send_frame(1, 1'b0, 10, 1'b0);
    #2 rst = 1'b1;
    #1 check("partial_rst_img_zero", bus.core_img == '0, 1);
    #1 rst = 1'b0;
    push(5, 32'd5, 1'b0, 50);
    send_frame(5, 1'b0, IMG_SIZE, 1'b0);
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
